i2c_ball_slave: RTL
===================

Name: i2c_ball_slave

Overview:
- I2C responder (write-only target) on the receiving board of the ball link.
- Decodes the write stream the ball I2C master produces: START, 0xAA, 0x00, Y_HI, Y_LO, 0x01, VY, STOP.
- Reconstructs ball_y[9:0] and ball_vy[7:0] and presents them, with a one-cycle valid strobe, to the game logic.
- Oversamples SCL/SDA on the system clock; the bus is open-drain and the block only ever drives SDA low.

Parameters:
- SLV_ADDR, 7'h55, 7-bit target address (address byte 0xAA = SLV_ADDR plus W=0).
- FILT_LEN, 3, consecutive identical synchronized samples required before a filtered SCL/SDA level changes.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- scl_i  in  1  raw SCL from pad.
- sda_i  in  1  raw SDA from pad.
- sda_oe  out  1  1 = pad drives SDA low (ACK); 0 = release.
- ball_y  out  10  last committed ball Y position.
- ball_vy  out  8  last committed ball Y velocity.
- ball_valid  out  1  one-cycle pulse when a new frame is committed.
- is_receiving  out  1  high from accepted START/address until STOP or abort.
- rx_error  out  1  one-cycle pulse on protocol error: unknown register, read request, or incomplete frame at STOP.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, shadow registers cleared. Asserting reset mid-transfer releases SDA immediately.
- Input path: 2-FF synchronizer, then a FILT_LEN glitch filter, then rise/fall edge detect, all per line. Latency from pad to filtered edge is 2+FILT_LEN clk.
- START: filtered SDA falls while SCL is high. Legal in any state, including a repeated START.
  - The bit counter and register pointer are cleared.
  - Shadow data is kept; shadow flags are cleared.
  - Go to RX_ADDR.
- STOP: filtered SDA rises while SCL is high. Legal in any state.
  - If both flags (y_ok, vy_ok) are set, copy the shadows to the outputs and pulse ball_valid in the same cycle the STOP is detected.
  - Else, if the address was matched, pulse rx_error.
  - Go to IDLE.
- Bit sampling: SDA is sampled on the filtered SCL rising edge, MSB first. Bit count runs 0..7.
- ACK timing:
  - sda_oe rises on the SCL falling edge after bit 7.
  - sda_oe falls on the next SCL falling edge (end of the 9th clock).
  - NACK means sda_oe stays 0 through the 9th clock.
- State machine:
  - IDLE: wait for START.
  - RX_ADDR: receive 8 bits.
    - Match {SLV_ADDR,0}: go to ACK_ADDR and set is_receiving.
    - Match {SLV_ADDR,1}: NACK, pulse rx_error, go to WAIT_STOP.
    - Any other address: NACK, go to WAIT_STOP, no error.
  - ACK_ADDR, then RX_REG: receive the register byte.
    - 0x00: ptr=Y, expected count=2.
    - 0x01: ptr=VY, expected count=1.
    - Any other value: NACK, pulse rx_error, go to WAIT_STOP.
  - ACK_REG, then RX_DATA: receive a data byte and ACK it in ACK_DATA.
    - Y, byte 0: y_hi_sh <= byte[7:6]. Bits [5:0] are ignored.
    - Y, byte 1: y_lo_sh <= byte; set y_ok.
    - VY: vy_sh <= byte; set vy_ok.
    - When the expected count reaches 0, the next byte is a register byte (go to RX_REG). Otherwise stay in RX_DATA.
  - WAIT_STOP: SDA not driven; wait for STOP or START.
- Output value: ball_y = {y_hi_sh, y_lo_sh}.
- Outputs change only at a committed STOP. They hold across errored or aborted frames.
- Re-writing a register inside one frame overwrites its shadow (last write wins).
- An SCL edge coincident with a START/STOP detect: START/STOP has priority.

Decomposition:
- Package i2c_ball_pkg:
  - Constants: I2C_BALL_ADDR=7'h55, REG_BALL_Y=8'h00, REG_BALL_VY=8'h01, REG_Y_LEN=2, REG_VY_LEN=1.
  - Typedef: slave state enum (IDLE, RX_ADDR, ACK_ADDR, RX_REG, ACK_REG, RX_DATA, ACK_DATA, WAIT_STOP).
  - The ball master controller imports the same constants.
- Sub-module i2c_line_filter: synchronizer, glitch filter and edge detect for one line. Instantiated twice (SCL and SDA).

Test Plan:
- Full frame, 100 kHz: 0xAA, 0x00, 0x80, 0xA5, 0x01, 0x7F, STOP -> 6 ACKs; ball_y=10'h2A5, ball_vy=8'h7F; one ball_valid pulse at STOP.
- Wrong address 0xA8 followed by data bytes -> no ACK, sda_oe never 1; outputs unchanged; no ball_valid, no rx_error.
- Register 0x05 after a valid address -> address ACKed, register byte NACKed, rx_error pulse; outputs unchanged at STOP.
- Frame with only reg 0x00 written (0xAA, 0x00, 0x40, 0x10, STOP) -> rx_error at STOP; ball_y keeps its previous value.
- Reset (reset=0) asserted during a Y_LO ACK -> sda_oe drops asynchronously; outputs 0. A following full frame commits normally.
- 1-clk glitch on SCL during a data bit with FILT_LEN=3 -> ignored; received byte correct. Repeated START mid-frame restarts decode; the final frame commits correctly.

Source files
------------

// File: rtl/i2c_ball_pkg.sv
// i2c_ball_pkg: constants and state type shared by the ball link I2C master and slave
package i2c_ball_pkg;
    localparam logic [6:0] I2C_BALL_ADDR = 7'h55;
    localparam logic [7:0] REG_BALL_Y = 8'h00;
    localparam logic [7:0] REG_BALL_VY = 8'h01;
    localparam int REG_Y_LEN = 2;
    localparam int REG_VY_LEN = 1;
    typedef enum logic [2:0] {
        IDLE, RX_ADDR, ACK_ADDR, RX_REG, ACK_REG, RX_DATA, ACK_DATA, WAIT_STOP
    } slv_state_t;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizer, glitch filter and edge detect for one open-drain line
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic level_q;
    // idle bus level is high, so resetting to 1 avoids a false edge on release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            cnt <= '0;
            level <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                level <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign rise = level & ~level_q;
    assign fall = ~level & level_q;
endmodule

// File: rtl/i2c_ball_slave.sv
// i2c_ball_slave: write-only I2C target decoding ball Y position/velocity frames
module i2c_ball_slave
    import i2c_ball_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = I2C_BALL_ADDR,
    parameter int FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [9:0] ball_y,
    output logic [7:0] ball_vy,
    output logic       ball_valid,
    output logic       is_receiving,
    output logic       rx_error
);
    logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    slv_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [1:0] remain;
    logic ptr_vy, y_ok, vy_ok, addr_ok;
    logic [1:0] y_hi_sh;
    logic [7:0] y_lo_sh, vy_sh;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .reset(reset), .raw(scl_i), .level(scl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .reset(reset), .raw(sda_i), .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    wire start = sda_fall & scl;
    wire stop = sda_rise & scl;
    wire [7:0] rx_byte = {shreg, sda};
    wire byte_done = scl_rise && bit_cnt == 3'd7;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            remain <= '0;
            ptr_vy <= 1'b0;
            y_ok <= 1'b0;
            vy_ok <= 1'b0;
            addr_ok <= 1'b0;
            y_hi_sh <= '0;
            y_lo_sh <= '0;
            vy_sh <= '0;
            sda_oe <= 1'b0;
            ball_y <= '0;
            ball_vy <= '0;
            ball_valid <= 1'b0;
            is_receiving <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            ball_valid <= 1'b0;
            rx_error <= 1'b0;
            if (start) begin
                state <= RX_ADDR;
                bit_cnt <= '0;
                remain <= '0;
                ptr_vy <= 1'b0;
                y_ok <= 1'b0;
                vy_ok <= 1'b0;
                addr_ok <= 1'b0;
                sda_oe <= 1'b0;
                is_receiving <= 1'b0;
            end else if (stop) begin
                if (y_ok && vy_ok) begin
                    ball_y <= {y_hi_sh, y_lo_sh};
                    ball_vy <= vy_sh;
                    ball_valid <= 1'b1;
                end else if (addr_ok) begin
                    rx_error <= 1'b1;
                end
                state <= IDLE;
                addr_ok <= 1'b0;
                sda_oe <= 1'b0;
                is_receiving <= 1'b0;
            end else begin
                case (state)
                    RX_ADDR, RX_REG, RX_DATA: if (scl_rise) begin
                        shreg <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_done && state == RX_ADDR) begin
                            if (rx_byte == {SLV_ADDR, 1'b0}) begin
                                state <= ACK_ADDR;
                                addr_ok <= 1'b1;
                                is_receiving <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                                rx_error <= rx_byte == {SLV_ADDR, 1'b1};
                            end
                        end else if (byte_done && state == RX_REG) begin
                            if (rx_byte == REG_BALL_Y || rx_byte == REG_BALL_VY) begin
                                state <= ACK_REG;
                                ptr_vy <= rx_byte == REG_BALL_VY;
                                remain <= rx_byte == REG_BALL_VY ? 2'(REG_VY_LEN) : 2'(REG_Y_LEN);
                            end else begin
                                state <= WAIT_STOP;
                                rx_error <= 1'b1;
                                is_receiving <= 1'b0;
                            end
                        end else if (byte_done) begin
                            state <= ACK_DATA;
                            remain <= remain - 1'b1;
                            if (ptr_vy) begin
                                vy_sh <= rx_byte;
                                vy_ok <= 1'b1;
                            end else if (remain == 2'(REG_Y_LEN)) begin
                                y_hi_sh <= rx_byte[7:6];
                            end else begin
                                y_lo_sh <= rx_byte;
                                y_ok <= 1'b1;
                            end
                        end
                    end
                    // first SCL fall drives the ACK, the second (end of 9th clock) releases it
                    ACK_ADDR, ACK_REG, ACK_DATA: if (scl_fall) begin
                        sda_oe <= ~sda_oe;
                        if (sda_oe)
                            state <= state == ACK_ADDR ? RX_REG :
                                     state == ACK_REG ? RX_DATA :
                                     remain == 2'd0 ? RX_REG : RX_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
